// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control with HI/LO registers
//
// Purpose: accepts MULT/MULTU/DIV/DIVU from the E stage, computes the 64-bit
// result up front into temp registers, then holds Busy for a fixed latency
// (5 cycles multiply, 10 cycles divide) before committing to HI/LO.
// MTHI/MTLO write HI/LO in one cycle; MFHI/MFLO read them combinationally.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   E_MDUOp   - E-stage MDU opcode (0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,
//               5 MFHI,6 MFLO,7 MTHI,8 MTLO, others NOP)
//   E_A, E_B  - forwarded rs / rt operands
//   Req       - flush of the E-stage instruction this cycle
//   D_MDUUse  - D-stage instruction is an MDU op
//   Busy      - multiply/divide in flight
//   Stall     - stall request to the hazard unit
//   HI, LO    - architectural HI/LO registers
//   MDUOut    - MFHI/MFLO read data (0 for other ops)
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  input  logic        D_MDUUse,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

  logic        busy;
  logic        is_start_op;
  logic        div_ovf;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign busy        = (cnt_q != 4'd0);
  assign is_start_op = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
  // The only signed quotient that does not fit in 32 bits.
  assign div_ovf     = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);

  always_comb begin
    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (E_B != 32'd0) begin
      quot_u = E_A / E_B;
      rem_u  = E_A % E_B;
      if (div_ovf) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        // Truncating division: remainder carries the dividend's sign.
        quot_s = $signed(E_A) / $signed(E_B);
        rem_s  = $signed(E_A) % $signed(E_B);
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    if (busy) begin
      // New E-stage ops are ignored while busy; Stall keeps them away.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else if (!Req) begin
      case (E_MDUOp)
        OP_MULT: begin
          cnt_d    = MUL_CYCLES;
          tmp_hi_d = prod_s[63:32];
          tmp_lo_d = prod_s[31:0];
        end
        OP_MULTU: begin
          cnt_d    = MUL_CYCLES;
          tmp_hi_d = prod_u[63:32];
          tmp_lo_d = prod_u[31:0];
        end
        OP_DIV, OP_DIVU: begin
          cnt_d = DIV_CYCLES;
          if (E_B == 32'd0) begin
            // Divide by zero: commit the current values so HI/LO stay put.
            tmp_hi_d = hi_q;
            tmp_lo_d = lo_q;
          end else if (E_MDUOp == OP_DIV) begin
            tmp_hi_d = rem_s;
            tmp_lo_d = quot_s;
          end else begin
            tmp_hi_d = rem_u;
            tmp_lo_d = quot_u;
          end
        end
        OP_MTHI: hi_d = E_A;
        OP_MTLO: lo_d = E_A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign Busy   = busy;
  assign Stall  = D_MDUUse && (busy || is_start_op);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = (E_MDUOp == OP_MFHI) ? hi_q :
                  (E_MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A, E_B;
  logic        Req, D_MDUUse;
  logic        Busy, Stall;
  logic [31:0] HI, LO, MDUOut;

  int n_checks = 0;
  int n_errors = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDUOp  (E_MDUOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .Req      (Req),
    .D_MDUUse (D_MDUUse),
    .Busy     (Busy),
    .Stall    (Stall),
    .HI       (HI),
    .LO       (LO),
    .MDUOut   (MDUOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: results from plain arithmetic, timing as an absolute
  // commit cycle number.
  int          m_n;
  int          m_done;
  logic        m_pend;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  function automatic logic m_busy();
    return m_n < m_done;
  endfunction

  task automatic model_reset;
    m_n = 0; m_done = 0; m_pend = 1'b0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl, output logic ok);
    longint sa, sb, p, q, r, mag_a, mag_b;
    longint unsigned pu;
    ok = 1'b1; rh = 0; rl = 0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      4'd2: begin pu = a; pu = pu * b; rh = pu[63:32]; rl = pu[31:0]; end
      4'd3: begin
        if (b == 0) ok = 1'b0;
        else begin
          mag_a = (sa < 0) ? -sa : sa;
          mag_b = (sb < 0) ? -sb : sb;
          q = mag_a / mag_b;
          if ((sa < 0) != (sb < 0)) q = -q;
          r = sa - q * sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      4'd4: begin
        if (b == 0) ok = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    logic was_busy, ok;
    logic [31:0] rh, rl;
    was_busy = m_busy();
    m_n++;
    if (m_pend && m_n == m_done) begin
      m_hi = m_phi; m_lo = m_plo; m_pend = 1'b0;
    end
    if (!was_busy && !req) begin
      if (op >= 1 && op <= 4) begin
        ref_result(op, a, b, rh, rl, ok);
        m_done = m_n + ((op <= 2) ? 5 : 10);
        m_pend = ok;
        m_phi = rh; m_plo = rl;
      end else if (op == 7) m_hi = a;
      else if (op == 8) m_lo = a;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0]  op;
    logic        dz;
    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,         5,  32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd4, 32'd7,         32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{4'd7, 32'hDEAD_BEEF, 32'd0,         0,  32'hDEAD_BEEF, 32'h8000_0000};
    vecs[6] = '{4'd8, 32'h0BAD_F00D, 32'd0,         0,  32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[7] = '{4'd4, 32'd100,       32'd7,         10, 32'd2,         32'd14};
    vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'd0};
    vecs[9] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};

    reset = 1'b1; E_MDUOp = 0; E_A = 0; E_B = 0; Req = 0; D_MDUUse = 0;
    #1;
    chk("reset_busy", {31'd0, Busy}, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    tick; tick;
    reset = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      E_MDUOp = vecs[i].op; E_A = vecs[i].a; E_B = vecs[i].b;
      tick;
      E_MDUOp = 0;
      for (int k = 0; k < vecs[i].busy_cyc; k++) begin
        chk($sformatf("v%0d_busy_c%0d", i, k + 1), {31'd0, Busy}, 1);
        tick;
      end
      chk($sformatf("v%0d_busy_end", i), {31'd0, Busy}, 0);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      E_MDUOp = 4'd5; #1;
      chk($sformatf("v%0d_mfhi", i), MDUOut, vecs[i].hi);
      E_MDUOp = 4'd6; #1;
      chk($sformatf("v%0d_mflo", i), MDUOut, vecs[i].lo);
      E_MDUOp = 4'd0; #1;
      chk($sformatf("v%0d_nop_out", i), MDUOut, 0);
    end

    // Stall across a multiply, then MFLO picks up the new LO.
    D_MDUUse = 1; E_MDUOp = 4'd1; E_A = 3; E_B = 5; #1;
    chk("stall_start", {31'd0, Stall}, 1);
    tick;
    E_MDUOp = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("stall_busy_c%0d", k + 1), {31'd0, Stall}, 1);
      tick;
    end
    chk("stall_after", {31'd0, Stall}, 0);
    E_MDUOp = 4'd6; #1;
    chk("stall_mflo", MDUOut, 32'd15);
    D_MDUUse = 0; E_MDUOp = 0;

    // Req suppresses a start but not an in-flight divide.
    E_MDUOp = 4'd1; E_A = 5; E_B = 5; Req = 1;
    tick;
    E_MDUOp = 0; Req = 0;
    chk("req_mult_busy", {31'd0, Busy}, 0);
    chk("req_mult_hi", HI, 0);
    chk("req_mult_lo", LO, 15);
    E_MDUOp = 4'd3; E_A = 100; E_B = 7;
    tick;
    for (int k = 1; k <= 10; k++) begin
      E_MDUOp = (k == 2) ? 4'd3 : 4'd0;
      E_A = 32'd9; E_B = 32'd3;
      Req = (k == 2);
      chk($sformatf("req_div_busy_c%0d", k), {31'd0, Busy}, 1);
      tick;
    end
    E_MDUOp = 0; Req = 0;
    chk("req_div_busy_end", {31'd0, Busy}, 0);
    chk("req_div_hi", HI, 2);
    chk("req_div_lo", LO, 14);

    // Reset in busy cycle 3 of a divide.
    E_MDUOp = 4'd3; E_A = 32'hFFFF_FFF9; E_B = 2;
    tick;
    E_MDUOp = 0;
    tick; tick;
    chk("rst_pre_busy", {31'd0, Busy}, 1);
    #2 reset = 1;
    #1;
    chk("rst_async_busy", {31'd0, Busy}, 0);
    chk("rst_async_hi", HI, 0);
    chk("rst_async_lo", LO, 0);
    D_MDUUse = 1; E_MDUOp = 4'd1; #1;
    chk("rst_stall_on", {31'd0, Stall}, 1);
    E_MDUOp = 4'd0; #1;
    chk("rst_stall_off", {31'd0, Stall}, 0);
    D_MDUUse = 0;
    tick; tick;
    reset = 0;
    for (int k = 0; k < 12; k++) tick;
    chk("rst_nocommit_busy", {31'd0, Busy}, 0);
    chk("rst_nocommit_hi", HI, 0);
    chk("rst_nocommit_lo", LO, 0);
    E_MDUOp = 4'd7; E_A = 32'h1234_5678;
    tick;
    E_MDUOp = 0;
    chk("mthi_after_rst", HI, 32'h1234_5678);

    // Randomized run against the reference model.
    reset = 1; #1; model_reset; tick; reset = 0;
    for (int c = 0; c < 600; c++) begin
      op = (($urandom % 3) == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      E_MDUOp = op;
      E_A = $urandom;
      dz = (($urandom % 6) == 0);
      E_B = dz ? 32'd0 : $urandom;
      if (($urandom % 10) == 0) begin E_A = 32'h8000_0000; E_B = 32'hFFFF_FFFF; end
      else if (($urandom % 4) == 0) E_B = 32'($urandom_range(1, 9));
      Req = (($urandom % 8) == 0);
      D_MDUUse = $urandom % 2;
      #1;
      chk("rnd_stall", {31'd0, Stall}, {31'd0, D_MDUUse && (m_busy() || (op >= 1 && op <= 4))});
      chk("rnd_mduout", MDUOut, (op == 5) ? m_hi : (op == 6) ? m_lo : 32'd0);
      if (($urandom % 60) == 0) begin
        reset = 1; #1;
        model_reset;
        chk("rnd_rst_busy", {31'd0, Busy}, 0);
        chk("rnd_rst_hi", HI, 0);
        @(posedge clk); #1;
        reset = 0;
      end else begin
        @(posedge clk);
        model_edge(op, E_A, E_B, Req);
        #1;
        chk("rnd_busy", {31'd0, Busy}, {31'd0, m_busy()});
        chk("rnd_hi", HI, m_hi);
        chk("rnd_lo", LO, m_lo);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL expose these ports, one per line (name  direction  width  meaning), clock and reset first:
- clk  input  1  single system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- E_MDUOp  input  4  E-stage multiply/divide opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NOP.
- E_A  input  32  rs operand, already forwarded.
- E_B  input  32  rt operand, already forwarded.
- Req  input  1  exception/interrupt flush; the E-stage instruction is being cancelled this cycle.
- D_MDUUse  input  1  the D-stage instruction is any MDU-class op (1-8).
- Busy  output  1  a multiply/divide is in flight.
- Stall  output  1  MDU stall request to the hazard unit.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUOut  output  32  E-stage read result for MFHI/MFLO.

Function
REQ-002 The block SHALL derive an effective start as E_MDUOp in {1,2,3,4}, Req = 0 and Busy = 0.
REQ-003 On an effective start, the block SHALL latch the full 64-bit result into internal temp registers and load the cycle counter: 5 for MULT/MULTU, 10 for DIV/DIVU.
REQ-004 Busy SHALL equal (counter != 0), so it rises on the edge after the start cycle.
REQ-005 Busy SHALL remain high for exactly 5 cycles for a multiply and 10 cycles for a divide.
REQ-006 The counter SHALL decrement by 1 each cycle while non-zero.
REQ-007 On the edge where the counter goes from 1 to 0, the block SHALL commit the temp registers to HI/LO.
REQ-008 New HI/LO values SHALL be visible in the first cycle with Busy = 0.
REQ-009 MULT SHALL compute a signed 64-bit product and MULTU an unsigned one; {HI,LO} = product[63:32], product[31:0].
REQ-010 DIV/DIVU SHALL set LO = quotient and HI = remainder, signed or unsigned respectively.
REQ-011 For signed division, the remainder SHALL take the sign of the dividend.
REQ-012 For divide by zero (E_B = 0), the block SHALL consume the full 10-cycle busy period and leave HI and LO unchanged at commit.
REQ-013 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-014 MTHI/MTLO with Req = 0 SHALL write E_A into HI/LO respectively on the next edge, in a single cycle.
REQ-015 Any start-class op (1-4) or MTHI/MTLO arriving while Busy = 1 SHALL be ignored; this is a protocol violation that Stall prevents in normal operation.
REQ-016 Req = 1 SHALL suppress the start or write of the E-stage op.
REQ-017 An operation already in flight SHALL NOT be cancelled by Req; it SHALL complete and commit normally.
REQ-018 MDUOut SHALL be combinational: HI when E_MDUOp = MFHI, LO when E_MDUOp = MFLO, 0 otherwise.
REQ-019 MDUOut SHALL reflect the committed HI/LO values, never the temp registers.
REQ-020 Stall SHALL equal D_MDUUse AND (Busy OR E_MDUOp in {1,2,3,4}).
REQ-021 Stall SHALL be purely combinational, with no registered delay.

Reset
REQ-022 Asserting reset SHALL immediately, asynchronously, clear the counter, temp registers, HI and LO to 0.
REQ-023 While reset is asserted, Busy = 0 and Stall depends only on D_MDUUse and E_MDUOp.
REQ-024 Reset during an in-flight operation SHALL abort it with no commit.
REQ-025 The first edge after reset deassertion SHALL accept a new start.

Verification
REQ-026 The bench SHALL run: MULT with E_A=0xFFFFFFFE (-2), E_B=3 -> Busy high for cycles 1-5 after start; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-027 The bench SHALL run: MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA, after 5 busy cycles.
REQ-028 The bench SHALL run: DIV of -7 by 2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU of 7 by 0 -> Busy for 10 cycles, HI/LO unchanged.
REQ-029 The bench SHALL run: MULT start with D_MDUUse=1 -> Stall=1 in the start cycle and the 5 busy cycles; Stall=0 in the first cycle after. MFLO in E then returns the new LO on MDUOut.
REQ-030 The bench SHALL run: MULT with Req=1 in the start cycle -> Busy stays 0, HI/LO unchanged. DIV started, then Req=1 two cycles later -> DIV still commits at cycle 10.
REQ-031 The bench SHALL run: reset asserted at busy cycle 3 of a DIV -> Busy, HI and LO go to 0 immediately, no later commit. MTHI 0x12345678 after reset release -> HI=0x12345678 on the next edge.
